// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, timing defaults
// and small elaboration-time helpers.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // One UART frame is 10 bits; 12 bit periods leaves margin before aborting.
  localparam int TIMEOUT_BITS = 12;

  function automatic int timeout_clks(input int clks_per_bit);
    return TIMEOUT_BITS * clks_per_bit;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching upward
// from last+1 with wrap-around.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester examined at search position gi (0 = highest priority)
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((int'(i_last) + gi + 1) % NUM_REQ);
    assign hit[gi]  = i_req[cand[gi]];
  end

  always_comb begin
    o_idx = i_last;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        o_idx = cand[k];
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources, with a watchdog that aborts a transfer whose done pulse never comes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int TIMEOUT_CLKS = timeout_clks(CLKS_PER_BIT),
  localparam int IDX_W        = idx_width(NUM_REQ)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [IDX_W-1:0]     o_Grant_Idx,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int               WD_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         byte_q, byte_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = i_Req_Byte[8*gi +: 8];
  end

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req  (i_Req_Valid),
    .i_last (last_q),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  // The watchdog is zero in the LAUNCH cycle and counts clocks since launch,
  // so its terminal value lands TIMEOUT_CLKS-1 cycles after o_TX_DV and the
  // registered o_Timeout pulse appears exactly TIMEOUT_CLKS cycles after it.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    byte_d    = byte_q;
    ready_d   = '0;
    dv_d      = 1'b0;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    wd_d      = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d           = ST_LAUNCH;
          last_d            = pick_idx;
          byte_d            = req_bytes[pick_idx];
          ready_d[pick_idx] = 1'b1;
          dv_d              = 1'b1;
          busy_d            = 1'b1;
          wd_d              = '0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
        wd_d    = wd_q + WD_W'(1);
      end
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      byte_q    <= 8'h00;
      ready_q   <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant_Idx = last_q;
  assign o_TX_DV     = dv_q;
  assign o_TX_Byte   = byte_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART_TX instance among NUM_REQ byte sources, e.g. RX loopback echo, a status/debug reporter and a display-value readback.
- Grants one requester at a time and launches that requester's byte into UART_TX.
- Holds the grant until the transmitter reports completion.
- A watchdog recovers the arbiter if completion never arrives.
- Sits between the requesters and UART_TX; the top level no longer wires RX DV/byte directly into TX.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- CLKS_PER_BIT, 104, UART bit period in clocks; must match the UART_TX instance.
- TIMEOUT_CLKS, 12*CLKS_PER_BIT, maximum clocks to wait for i_TX_Done after launch before aborting.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset; asynchronous, active-high.
- i_Req_Valid  in  NUM_REQ  per-requester "byte pending"; bit k belongs to requester k.
- i_Req_Byte  in  8*NUM_REQ  requester k's byte in bits [8k+7:8k].
- o_Req_Ready  out  NUM_REQ  one-cycle accept pulse; byte k is consumed in that cycle.
- o_Grant_Idx  out  clog2(NUM_REQ)  index of the current or last granted requester.
- o_TX_DV  out  1  one-cycle launch strobe to UART_TX i_TX_DV.
- o_TX_Byte  out  8  byte to UART_TX i_TX_Byte; registered and held until the next launch.
- i_TX_Done  in  1  UART_TX o_TX_Done pulse.
- o_Busy  out  1  high from the launch cycle until return to IDLE.
- o_Timeout  out  1  one-cycle pulse when the watchdog aborts a transfer.

Behaviour:
- Reset values (async, active-high): state=IDLE, o_Req_Ready=0, o_TX_DV=0, o_TX_Byte=8'h00, o_Busy=0, o_Timeout=0, watchdog=0, last-grant pointer=NUM_REQ-1, so requester 0 has top priority after reset. o_Grant_Idx=NUM_REQ-1.
- States:
  - IDLE:
    - If any i_Req_Valid is high, select the first set bit, searching from (last+1) mod NUM_REQ upward with wrap.
    - Register that requester's byte into o_TX_Byte, its index into o_Grant_Idx and last, and go to LAUNCH.
    - With no request, stay in IDLE.
  - LAUNCH (exactly 1 cycle):
    - o_TX_DV=1, o_Req_Ready[grant]=1, o_Busy=1; clear watchdog; go to WAIT_DONE.
  - WAIT_DONE:
    - o_Busy=1; watchdog increments every cycle.
    - If i_TX_Done=1, go to IDLE.
    - Else, if watchdog==TIMEOUT_CLKS-1, pulse o_Timeout for 1 cycle and go to IDLE.
- Latency:
  - Valid seen in IDLE at cycle t -> o_TX_DV and o_Req_Ready at t+1.
  - i_TX_Done at cycle d -> IDLE at d+1 -> earliest next o_TX_DV at d+2.
- Handshake rules:
  - A requester holds valid and byte stable until it sees its ready pulse, then drops valid (or presents its next byte) on the following cycle.
  - Valid is sampled only in IDLE; a valid withdrawn before the grant is simply not served.
  - Byte changes after the IDLE sampling cycle are ignored; the byte was captured.
  - At most one o_Req_Ready bit is high in any cycle; o_Req_Ready and o_TX_DV are always coincident.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 transfers.
- Boundary conditions:
  - i_TX_Done outside WAIT_DONE is ignored.
  - i_TX_Done in the same cycle the watchdog reaches its terminal count: done wins, no o_Timeout.
  - After a timeout the pointer still advances, so a stuck transfer cannot starve the other requesters.
  - Reset mid-transfer returns immediately to reset values; the interrupted byte is not retried.
  - Watchdog width is clog2(TIMEOUT_CLKS); it never wraps, because it is cleared on LAUNCH.

Decomposition:
- Shared package: state encoding (IDLE, LAUNCH, WAIT_DONE) and the default timeout constant 12*CLKS_PER_BIT.
- One sub-module is natural: rr_pick, a combinational round-robin priority selector. Inputs: request vector and last pointer. Outputs: grant index and an any-valid flag. It is reusable for a future display-source arbiter.

Test Plan:
1. Reset, then valid[0]=1 with byte 8'h41 -> o_TX_DV and o_Req_Ready=2'b01 one cycle later, o_TX_Byte=8'h41, o_Grant_Idx=0; o_Busy stays high until the cycle after i_TX_Done.
2. NUM_REQ=3, all valid constantly with bytes 8'hA0/8'hB1/8'hC2, model TX Done 1040 clocks after DV -> launched bytes A0,B1,C2,A0,B1,C2.
3. valid[0] and valid[1] rise in the same cycle right after a grant to 0 -> next grant goes to 1, then 0.
4. Launch, then withhold i_TX_Done -> o_Timeout pulses exactly TIMEOUT_CLKS cycles after o_TX_DV; back in IDLE; the next pending requester is served.
5. i_TX_Done asserted on the watchdog terminal cycle -> no o_Timeout, normal return to IDLE. Stray i_TX_Done while in IDLE -> no state change.
6. Assert i_Rst asynchronously in WAIT_DONE -> all outputs return to reset values before the next clock edge; after release requester 0 has priority.
